id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between decode and the execute stage; drives ALU32 operands (`in1`, `in2`) and `op` directly from flops.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB writeback buses at capture time.
- Inserts bubbles on stall or flush, and holds its contents while execute is busy.

Parameters:
- WIDTH, 32, datapath width.
- OPWIDTH, 6, ALU op-code width, matching the decoder op list.
- RADDR, 5, register address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- id_valid  input  1  decode slot holds a real instruction.
- id_op  input  OPWIDTH  ALU op from decoder.
- id_rs1  input  RADDR  source register 1 address.
- id_rs2  input  RADDR  source register 2 address.
- id_rd  input  RADDR  destination register address.
- id_we  input  1  instruction writes rd.
- id_rs1_val  input  WIDTH  register file read data for rs1.
- id_rs2_val  input  WIDTH  register file read data for rs2.
- id_imm  input  WIDTH  sign-extended immediate.
- id_use_imm  input  1  in2 takes id_imm instead of rs2.
- stall  input  1  load-use stall; load a bubble.
- flush  input  1  branch redirect; load a bubble.
- ex_hold  input  1  execute busy; freeze the register.
- exm_we  input  1  EX/MEM result writes a register.
- exm_rd  input  RADDR  EX/MEM destination.
- exm_val  input  WIDTH  EX/MEM result.
- mwb_we  input  1  MEM/WB result writes a register.
- mwb_rd  input  RADDR  MEM/WB destination.
- mwb_val  input  WIDTH  MEM/WB result.
- ex_valid  output  1  execute slot valid.
- ex_op  output  OPWIDTH  op to ALU32.
- ex_in1  output  WIDTH  ALU32 in1.
- ex_in2  output  WIDTH  ALU32 in2.
- ex_rd  output  RADDR  destination, carried forward.
- ex_we  output  1  write-enable, carried forward; forced 0 when ex_valid=0.

Behaviour:
- All outputs registered; latency one clk from id_* to ex_*. No combinational path from any input to any output.
- Reset (sync, active-high): ex_valid=0, ex_we=0, ex_op=0, ex_in1=0, ex_in2=0, ex_rd=0.
- Per-edge priority: reset > flush > ex_hold > stall > load.
- flush: bubble, i.e. ex_valid=0 and ex_we=0.
  - Data fields may keep old values but must not propagate a write.
  - flush overrides ex_hold.
- ex_hold (no flush): every output keeps its value. Forwarding buses are ignored.
- stall (no flush/hold): bubble, same as flush.
- load: all ex_* fields capture the id_* path.
  - ex_valid=id_valid.
  - ex_we=id_we & id_valid.
- Forwarded operand A, from rs1:
  - exm_val if exm_we and exm_rd==id_rs1 and id_rs1!=0;
  - else mwb_val if mwb_we and mwb_rd==id_rs1 and id_rs1!=0;
  - else id_rs1_val.
- Forwarded operand B: same rule on rs2.
- ex_in1 = A.
- ex_in2 = id_imm when id_use_imm, otherwise B. rs2 forwarding is not applied when id_use_imm=1.
- x0 is never forwarded, even if a producer targets rd=0 with we=1.
- When EX/MEM and MEM/WB both match the same source, EX/MEM wins.
- Reset asserted mid-hold or mid-stall clears the stage regardless of the other controls.

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- When defined:
  - Extra output bubble_cnt, 32 bits.
  - Increments on each edge where a bubble is loaded by stall or flush; not counted on hold cycles.
  - Saturates at 0xFFFFFFFF; cleared by reset.
- When undefined: no port and no counter logic; everything else is identical.

Test Plan:
- Reset then load: reset 2 cycles, then id_valid=1, op=3, rs1_val=0x00000005, rs2_val=0x00000007, no forwarding matches. Next edge: ex_valid=1, ex_in1=0x00000005, ex_in2=0x00000007, ex_op=3.
- Forward priority: id_rs1=4; exm_we=1, exm_rd=4, exm_val=0xAAAA0000; mwb_we=1, mwb_rd=4, mwb_val=0x5555FFFF. Required: ex_in1=0xAAAA0000. Then drop exm_we: ex_in1=0x5555FFFF.
- x0 guard and immediate:
  - id_rs1=0, exm_we=1, exm_rd=0, exm_val=0xDEADBEEF, id_rs1_val=0 → ex_in1=0.
  - id_use_imm=1, id_imm=0xFFFFFFF0, rs2 matching exm_rd → ex_in2=0xFFFFFFF0.
- Stall/hold/flush priority:
  - Loaded valid instruction, then ex_hold=1 for 3 cycles with changing id_* → outputs unchanged.
  - ex_hold=1 with flush=1 → ex_valid=0, ex_we=0.
  - stall=1 alone → bubble.
- Reset mid-hold: ex_hold=1, valid instruction held, assert reset one cycle → all outputs 0 on the next edge.
- ID_EX_BUBBLE_CNT_EN defined: 2 stall cycles, 1 flush, 3 hold cycles → bubble_cnt=3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode slot, pipeline control, writeback forwarding
// buses and the registered execute-stage outputs.
interface id_ex_stage_if #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 6,
  parameter int RADDR   = 5
);
  logic               id_valid;
  logic [OPWIDTH-1:0] id_op;
  logic [RADDR-1:0]   id_rs1;
  logic [RADDR-1:0]   id_rs2;
  logic [RADDR-1:0]   id_rd;
  logic               id_we;
  logic [WIDTH-1:0]   id_rs1_val;
  logic [WIDTH-1:0]   id_rs2_val;
  logic [WIDTH-1:0]   id_imm;
  logic               id_use_imm;

  logic               stall;
  logic               flush;
  logic               ex_hold;

  logic               exm_we;
  logic [RADDR-1:0]   exm_rd;
  logic [WIDTH-1:0]   exm_val;
  logic               mwb_we;
  logic [RADDR-1:0]   mwb_rd;
  logic [WIDTH-1:0]   mwb_val;

  logic               ex_valid;
  logic [OPWIDTH-1:0] ex_op;
  logic [WIDTH-1:0]   ex_in1;
  logic [WIDTH-1:0]   ex_in2;
  logic [RADDR-1:0]   ex_rd;
  logic               ex_we;

  modport master (
    output id_valid, id_op, id_rs1, id_rs2, id_rd, id_we,
           id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           stall, flush, ex_hold,
           exm_we, exm_rd, exm_val, mwb_we, mwb_rd, mwb_val,
    input  ex_valid, ex_op, ex_in1, ex_in2, ex_rd, ex_we
  );

  modport slave (
    input  id_valid, id_op, id_rs1, id_rs2, id_rd, id_we,
           id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           stall, flush, ex_hold,
           exm_we, exm_rd, exm_val, mwb_we, mwb_rd, mwb_val,
    output ex_valid, ex_op, ex_in1, ex_in2, ex_rd, ex_we
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 6,
  parameter int RADDR   = 5
) (
  input  logic         clk,
  input  logic         reset,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]  bubble_cnt,
`endif
  id_ex_stage_if.slave bus
);

  logic               r_valid;
  logic               r_we;
  logic [OPWIDTH-1:0] r_op;
  logic [WIDTH-1:0]   r_in1;
  logic [WIDTH-1:0]   r_in2;
  logic [RADDR-1:0]   r_rd;

  logic [WIDTH-1:0]   w_fwd_a;
  logic [WIDTH-1:0]   w_fwd_b;
  logic [WIDTH-1:0]   w_in2;
  logic               w_bubble;

  // EX/MEM is younger than MEM/WB, so it wins; x0 is hardwired and never forwarded.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fwd_a = bus.id_rs1_val;
    if (bus.exm_we && bus.exm_rd == bus.id_rs1 && bus.id_rs1 != '0)
      w_fwd_a = bus.exm_val;
    else if (bus.mwb_we && bus.mwb_rd == bus.id_rs1 && bus.id_rs1 != '0)
      w_fwd_a = bus.mwb_val;
  end

  always_comb begin
    w_fwd_b = bus.id_rs2_val;
    if (bus.exm_we && bus.exm_rd == bus.id_rs2 && bus.id_rs2 != '0)
      w_fwd_b = bus.exm_val;
    else if (bus.mwb_we && bus.mwb_rd == bus.id_rs2 && bus.id_rs2 != '0)
      w_fwd_b = bus.mwb_val;
  end

  assign w_in2    = bus.id_use_imm ? bus.id_imm : w_fwd_b;
  assign w_bubble = bus.flush || (!bus.ex_hold && bus.stall);

  // Bubbles clear only valid/we; stale data fields are harmless without a write.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_op    <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_rd    <= '0;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end else if (!bus.ex_hold) begin
      r_valid <= bus.id_valid;
      r_we    <= bus.id_we & bus.id_valid;
      r_op    <= bus.id_op;
      r_in1   <= w_fwd_a;
      r_in2   <= w_in2;
      r_rd    <= bus.id_rd;
    end
  end

  assign bus.ex_valid = r_valid;
  assign bus.ex_we    = r_we;
  assign bus.ex_op    = r_op;
  assign bus.ex_in1   = r_in1;
  assign bus.ex_in2   = r_in2;
  assign bus.ex_rd    = r_rd;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_bubble_cnt <= '0;
    else if (w_bubble && r_bubble_cnt != 32'hFFFF_FFFF)
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
